input_unloader: RTL and testbench
=================================

// Module: input_unloader
// PURPOSE
//   Receiver for the nibble-serial byte stream produced by the output loader. Each beat byte is
//   {mode[2:0], rdy, nibble[3:0]}. A frame is 2*W/4 consecutive rdy=1 beats carrying word A and
//   then word B, each MSB nibble first. The block rebuilds mode, word A and word B, flags framing
//   errors, and counts frames. It sits on the ingest side of the link, feeding the checker logic.
// PARAMETERS
//   W         32   word width in bits; must be a multiple of 4; NIB = W/4 nibbles per word
//   CNT_W     16   width of good-frame counter
// PORTS
//   clk          in   1      system clock; all logic on rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   in_byte      in   8      stream beat: [7:5] mode, [4] rdy, [3:0] nibble
//   busy         out  1      1 while a frame is partially received (state != IDLE)
//   frame_valid  out  1      1-cycle pulse: word_a/word_b/mode_out updated with a complete frame
//   frame_err    out  1      1-cycle pulse: frame aborted (rdy drop or mode change mid-frame)
//   mode_out     out  3      mode of last good frame
//   word_a       out  W      word A of last good frame
//   word_b       out  W      word B of last good frame
//   frame_cnt    out  CNT_W  good frames received; wraps 2^CNT_W-1 -> 0
//   err_cnt      out  8      aborted frames; saturates at 255
// BEHAVIOUR
//   Reset: every output 0, state IDLE, shift regs and beat count 0. Reset mid-frame discards it.
//   Sampling: in_byte is registered on every edge. Bits [7:5],[3:0] are ignored when rdy=0.
//   FSM: IDLE, RECV_A, RECV_B. beat counter 0..2*NIB-1. shift_a/shift_b: shift left 4, nibble in LSB.
//   IDLE: rdy=1 -> cur_mode<=in[7:5], shift_a<=nibble, beat=1, RECV_A. rdy=0 -> stay.
//   RECV_A: rdy=1 and mode==cur_mode -> shift into shift_a, beat+1. After NIB beats total -> RECV_B.
//   RECV_B: same for shift_b. On beat 2*NIB (last) -> registered update of word_a, word_b and
//     mode_out, plus frame_valid=1 and frame_cnt+1, all on the edge that samples that beat.
//     Then go to IDLE. This gives latency 0 cycles after the last beat's sampling edge.
//   Abort (RECV_A/RECV_B): if rdy=0 -> frame_err pulse, err_cnt+1 (sat), -> IDLE. Outputs keep
//     the previous good frame. If rdy=1 and mode!=cur_mode -> frame_err pulse, err_cnt+1, and the
//     current beat starts a new frame (cur_mode<=new mode, beat=1, RECV_A).
//   A frame truncated to 2*NIB-1 beats followed by rdy=0 is an abort, not a good frame.
//   Back-to-back: a rdy=1 beat on the cycle right after a completed frame starts a new frame
//     (IDLE is transited within the same edge: completion edge goes to IDLE; next beat handled there).
//     The completion edge itself consumes only the last beat. No gap is required.
//   frame_valid and frame_err are never high together. Both are 0 the cycle after a pulse unless
//     a new event occurs. busy is combinational from state.
// TESTING
//   1 Good frame: mode=3'b101, A=0x12345678, B=0x9ABCDEF0 as beats 0xB1..0xB8,0xB9,0xBA..0xBF,0xB0.
//     Required: one frame_valid, word_a=0x12345678, word_b=0x9ABCDEF0, mode_out=5, frame_cnt=1.
//   2 Truncation: the same frame with the 16th beat replaced by 0x00.
//     Required: frame_err pulse, no frame_valid, err_cnt=1, outputs unchanged, busy=0.
//   3 Mode change: beat 5 carries mode 3'b010, followed by 15 more mode-2 beats.
//     Required: frame_err on beat 5, then frame_valid with mode_out=2 and words from the new
//     16 beats.
//   4 Back-to-back: two good frames with no idle cycle between them.
//     Required: frame_valid pulses 16 cycles apart, both frames' words correct, frame_cnt=2.
//   5 Reset mid-frame: rst_n low at beat 8.
//     Required: all outputs 0 asynchronously. A following full frame is received correctly.
//   6 Saturation: 260 aborted frames (1 beat then 0x00 each).
//     Required: err_cnt stops at 255, frame_cnt=0.

Source files
------------

// File: rtl/input_unloader.sv
// input_unloader: rebuilds mode, word A and word B from a nibble-serial beat stream,
// flagging aborted frames and counting good and aborted frames.
module input_unloader #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  output logic             busy,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [2:0]       mode_out,
  output logic [W-1:0]     word_a,
  output logic [W-1:0]     word_b,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt
);
  localparam int NIB = W / 4;
  localparam int BW  = $clog2(2 * NIB);
  localparam logic [BW-1:0] LAST_A = BW'(NIB - 1);
  localparam logic [BW-1:0] LAST_B = BW'(2 * NIB - 1);
  typedef enum logic [1:0] {IDLE, RECV_A, RECV_B} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat, beat_nx;
  logic [2:0] cur_mode, cur_mode_nx;
  logic [W-1:0] shift_a, shift_a_nx, shift_b, shift_b_nx;
  logic done, abort, start;
  logic [2:0] mode_in;
  logic rdy;
  logic [3:0] nib;
  assign mode_in = in_byte[7:5];
  assign rdy     = in_byte[4];
  assign nib     = in_byte[3:0];
  assign busy    = state != IDLE;
  always_comb begin
    state_nx    = state;
    beat_nx     = beat;
    cur_mode_nx = cur_mode;
    shift_a_nx  = shift_a;
    shift_b_nx  = shift_b;
    done        = 1'b0;
    abort       = 1'b0;
    start       = 1'b0;
    if (state == IDLE) begin
      start = rdy;
    end else if (!rdy) begin
      abort    = 1'b1;
      state_nx = IDLE;
      beat_nx  = '0;
    end else if (mode_in != cur_mode) begin
      // a mode change both aborts the old frame and opens a new one with this beat
      abort = 1'b1;
      start = 1'b1;
    end else if (state == RECV_A) begin
      shift_a_nx = {shift_a[W-5:0], nib};
      beat_nx    = beat + 1'b1;
      state_nx   = beat == LAST_A ? RECV_B : RECV_A;
    end else begin
      shift_b_nx = {shift_b[W-5:0], nib};
      done       = beat == LAST_B;
      beat_nx    = done ? '0 : beat + 1'b1;
      state_nx   = done ? IDLE : RECV_B;
    end
    if (start) begin
      cur_mode_nx = mode_in;
      shift_a_nx  = W'(nib);
      shift_b_nx  = '0;
      beat_nx     = BW'(1);
      state_nx    = NIB == 1 ? RECV_B : RECV_A;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= '0;
      cur_mode    <= '0;
      shift_a     <= '0;
      shift_b     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      mode_out    <= '0;
      word_a      <= '0;
      word_b      <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nx;
      beat        <= beat_nx;
      cur_mode    <= cur_mode_nx;
      shift_a     <= shift_a_nx;
      shift_b     <= shift_b_nx;
      frame_valid <= done;
      frame_err   <= abort;
      if (done) begin
        mode_out  <= cur_mode;
        word_a    <= shift_a;
        word_b    <= shift_b_nx;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_input_unloader.sv
// tb_input_unloader: directed stimulus with hand-computed expectations for input_unloader.
module tb_input_unloader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        busy, frame_valid, frame_err;
  logic [2:0]  mode_out;
  logic [31:0] word_a, word_b;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  int total = 0;
  int bad = 0;
  input_unloader #(.W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .busy(busy),
    .frame_valid(frame_valid), .frame_err(frame_err), .mode_out(mode_out),
    .word_a(word_a), .word_b(word_b), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    in_byte = b;
    @(posedge clk);
    #1;
  endtask
  task automatic send_words(input logic [2:0] m, input logic [63:0] ab, input int first, input int last);
    for (int i = first; i <= last; i++) send({m, 1'b1, ab[63-4*i -: 4]});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", frame_valid, 0);
    chk("reset_word_a", word_a, 0);
    chk("reset_cnt", {frame_cnt, err_cnt}, 0);
    rst_n = 1'b1;
    send(8'h00);
    chk("idle_busy", busy, 0);
    // good frame
    send_words(3'd5, 64'h12345678_9ABCDEF0, 0, 14);
    chk("t1_busy_mid", busy, 1);
    chk("t1_no_valid_yet", frame_valid, 0);
    send_words(3'd5, 64'h12345678_9ABCDEF0, 15, 15);
    chk("t1_valid", frame_valid, 1);
    chk("t1_err", frame_err, 0);
    chk("t1_word_a", word_a, 32'h12345678);
    chk("t1_word_b", word_b, 32'h9ABCDEF0);
    chk("t1_mode", mode_out, 5);
    chk("t1_cnt", frame_cnt, 1);
    chk("t1_busy", busy, 0);
    send(8'h00);
    chk("t1_valid_clear", frame_valid, 0);
    // truncation
    send_words(3'd5, 64'h11112222_33334444, 0, 14);
    send(8'h00);
    chk("t2_err", frame_err, 1);
    chk("t2_valid", frame_valid, 0);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_word_a", word_a, 32'h12345678);
    chk("t2_word_b", word_b, 32'h9ABCDEF0);
    chk("t2_cnt", frame_cnt, 1);
    chk("t2_busy", busy, 0);
    send(8'h00);
    chk("t2_err_clear", frame_err, 0);
    // mode change at beat 5 restarts the frame in mode 2
    send_words(3'd5, 64'hAAAAAAAA_AAAAAAAA, 0, 3);
    chk("t3_no_err_yet", frame_err, 0);
    send_words(3'd2, 64'h0F1E2D3C_4B5A6978, 0, 0);
    chk("t3_err", frame_err, 1);
    chk("t3_err_cnt", err_cnt, 2);
    chk("t3_busy", busy, 1);
    send_words(3'd2, 64'h0F1E2D3C_4B5A6978, 1, 1);
    chk("t3_err_clear", frame_err, 0);
    send_words(3'd2, 64'h0F1E2D3C_4B5A6978, 2, 15);
    chk("t3_valid", frame_valid, 1);
    chk("t3_mode", mode_out, 2);
    chk("t3_word_a", word_a, 32'h0F1E2D3C);
    chk("t3_word_b", word_b, 32'h4B5A6978);
    chk("t3_cnt", frame_cnt, 2);
    // back-to-back frames, no idle beat
    send_words(3'd7, 64'hDEADBEEF_01234567, 0, 15);
    chk("t4_valid1", frame_valid, 1);
    chk("t4_word_a1", word_a, 32'hDEADBEEF);
    chk("t4_word_b1", word_b, 32'h01234567);
    send_words(3'd1, 64'h89ABCDEF_FEDCBA98, 0, 0);
    chk("t4_valid_gap", frame_valid, 0);
    chk("t4_busy_gap", busy, 1);
    chk("t4_hold_a", word_a, 32'hDEADBEEF);
    send_words(3'd1, 64'h89ABCDEF_FEDCBA98, 1, 14);
    chk("t4_no_valid_early", frame_valid, 0);
    send_words(3'd1, 64'h89ABCDEF_FEDCBA98, 15, 15);
    chk("t4_valid2", frame_valid, 1);
    chk("t4_mode2", mode_out, 1);
    chk("t4_word_a2", word_a, 32'h89ABCDEF);
    chk("t4_word_b2", word_b, 32'hFEDCBA98);
    chk("t4_cnt", frame_cnt, 4);
    chk("t4_err_cnt", err_cnt, 2);
    // asynchronous reset mid-frame
    send_words(3'd3, 64'h55555555_66666666, 0, 6);
    in_byte = 8'h7F;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_word_a", word_a, 0);
    chk("t5_word_b", word_b, 0);
    chk("t5_mode", mode_out, 0);
    chk("t5_cnts", {frame_cnt, err_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_words(3'd3, 64'hC0FFEE00_BADC0DE5, 0, 15);
    chk("t5_valid", frame_valid, 1);
    chk("t5_word_a_new", word_a, 32'hC0FFEE00);
    chk("t5_word_b_new", word_b, 32'hBADC0DE5);
    chk("t5_cnt", frame_cnt, 1);
    // saturation of the error counter
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send(8'h31);
      send(8'h00);
      if (i == 254) chk("t6_err_255", err_cnt, 255);
    end
    chk("t6_err_pulse", frame_err, 1);
    chk("t6_err_sat", err_cnt, 255);
    chk("t6_cnt", frame_cnt, 0);
    chk("t6_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
